// File: rtl/bram_s18_read_streamer_pkg.sv
// Shared types and constants for the 18-bit-port block RAM read streamer.
package bram_s18_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_PAR_W  = 2;

  localparam int FIFO_DEPTH = 3;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/bram_s18_read_streamer_capture_fifo.sv
// Three-entry capture FIFO holding returned RAM words; the head entry drives the output stream.
module bram_s18_capture_fifo
  import bram_s18_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W + DEF_PAR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      head_o,
  output logic                  valid_o,
  output logic [FIFO_CNT_W-1:0] count_o
);

  logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_CNT_W-1:0] count_q;
  logic                  do_push, do_pop;

  function automatic logic [FIFO_PTR_W-1:0] next_ptr(input logic [FIFO_PTR_W-1:0] p);
    return (p == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + FIFO_PTR_W'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FIFO_CNT_W'(FIFO_DEPTH)) || do_pop);

  // NOTE: the storage is reset too, so the stream data outputs read as zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + FIFO_CNT_W'(1);
        2'b01:   count_q <= count_q - FIFO_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/bram_s18_read_streamer.sv
// Streams cmd_len_i words from an 18-bit-port block RAM starting at cmd_base_i.
// Optional parity checking with sticky par_err_o: define BRAM_S18_READ_STREAMER_PARITY_CHK_EN.
module bram_s18_read_streamer
  import bram_s18_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int PAR_W  = DEF_PAR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_base_i,
  input  logic [ADDR_W:0]   cmd_len_i,
  output logic              ram_en_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic              ram_ssr_o,
  input  logic [DATA_W-1:0] ram_do_i,
  input  logic [PAR_W-1:0]  ram_dop_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [PAR_W-1:0]  m_par_o,
  output logic              m_last_o,
  output logic              done_o
`ifdef BRAM_S18_READ_STREAMER_PARITY_CHK_EN
  ,
  output logic              par_err_o
`endif
);

  localparam int ENTRY_W = DATA_W + PAR_W + 1;
  localparam int OCC_W   = FIFO_CNT_W + 1;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W:0]       rem_q, rem_d;
  logic                  done_q, done_d;
  logic                  inflight_q, inflight_last_q;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [OCC_W-1:0]      occupancy;
  logic [ENTRY_W-1:0]    fifo_head;
  logic                  accept, issue, last_issue, consume;

  assign cmd_ready_o = (state_q == IDLE);
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign consume     = m_valid_o & m_ready_i;

  // Words already captured plus the one returning this cycle must leave room for a new read.
  assign occupancy  = OCC_W'(fifo_count) + OCC_W'(inflight_q);
  assign issue      = (state_q == RUN) && (rem_q != '0) && (occupancy < OCC_W'(FIFO_DEPTH));
  assign last_issue = issue && (rem_q == (ADDR_W+1)'(1));

  // NOTE: every next-state variable gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = cmd_base_i;
          rem_d  = cmd_len_i;
          if (cmd_len_i == '0) done_d  = 1'b1;
          else                 state_d = RUN;
        end
      end
      RUN: begin
        if (issue) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - (ADDR_W+1)'(1);
          if (last_issue) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (consume && m_last_o) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      done_q          <= done_d;
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
    end
  end

  assign ram_en_o   = issue;
  assign ram_addr_o = addr_q;
  assign ram_we_o   = 1'b0;
  assign ram_ssr_o  = 1'b0;
  assign done_o     = done_q;

  bram_s18_capture_fifo #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (inflight_q),
    .push_data_i({inflight_last_q, ram_dop_i, ram_do_i}),
    .pop_i      (consume),
    .head_o     (fifo_head),
    .valid_o    (m_valid_o),
    .count_o    (fifo_count)
  );

  assign {m_last_o, m_par_o, m_data_o} = fifo_head;

`ifdef BRAM_S18_READ_STREAMER_PARITY_CHK_EN
  logic par_err_q;
  logic par_bad;

  always_comb begin
    par_bad = 1'b0;
    for (int i = 0; i < PAR_W; i++) begin
      if (m_par_o[i] != ^m_data_o[8*i +: 8]) par_bad = 1'b1;
    end
  end

  // Sticky until the next command is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 par_err_q <= 1'b0;
    else if (accept)            par_err_q <= 1'b0;
    else if (consume & par_bad) par_err_q <= 1'b1;
  end

  assign par_err_o = par_err_q;
`endif

endmodule
